// File: rtl/collision_scan_ctrl.sv
// collision_scan_ctrl
//
// Purpose:
//   Sequential collision scheduler. On an accepted start it latches the
//   doodle position. It then walks every platform slot, one per cycle,
//   through a single read port on the block table, which has a one-cycle
//   read latency. Each returned entry goes through one shared comparator.
//   When the walk finishes, the block reports the winning hit with a
//   one-cycle done pulse.
//
// Ports:
//   clk, rst_n      - clock (rising edge) and asynchronous active-low reset
//   start           - scan request, only honoured while idle
//   doodleX/Y       - doodle position, captured when start is accepted
//   rd_en, rd_addr  - read strobe and slot index towards the block table
//   rd_x/y, rd_active - table data for the slot addressed one cycle earlier
//   busy            - scan in progress (acceptance through cycle before done)
//   done            - one-cycle pulse, results valid from this cycle
//   hasCollide      - last completed scan found a hit
//   collisionX/Y    - block coordinates of the winning slot
//   collisionIndex  - index of the winning slot

module collision_scan_ctrl #(
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 700,
    parameter int BLOCK_WIDTH   = 40,
    parameter int BLOCK_HEIGHT  = 5,
    localparam int COUNT_BLOCKS = (SCREEN_WIDTH / BLOCK_WIDTH) * (SCREEN_HEIGHT / BLOCK_HEIGHT),
    localparam int IDX_W_RAW    = $clog2(COUNT_BLOCKS),
    localparam int IDX_W        = (IDX_W_RAW < 1) ? 1 : IDX_W_RAW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      doodleX,
    input  logic [31:0]      doodleY,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [31:0]      rd_x,
    input  logic [31:0]      rd_y,
    input  logic             rd_active,
    output logic             busy,
    output logic             done,
    output logic             hasCollide,
    output logic [31:0]      collisionX,
    output logic [31:0]      collisionY,
    output logic [IDX_W-1:0] collisionIndex
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT_BLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [IDX_W-1:0] counter;
    logic [31:0]      lat_x, lat_y;

    // Compare-stage pipeline tag: marks the cycle in which table data is
    // valid, and records which slot that data belongs to.
    logic             cmp_valid;
    logic [IDX_W-1:0] cmp_idx;

    // Working hit registers, accumulated during the scan.
    logic             work_hit;
    logic [31:0]      work_x, work_y;
    logic [IDX_W-1:0] work_idx;

    logic             slot_hit;
    logic [32:0]      x_right;
    logic             work_hit_nx;
    logic [31:0]      work_x_nx, work_y_nx;
    logic [IDX_W-1:0] work_idx_nx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control outputs. The last scan cycle is the one in
    // which the final slot address is issued. DRAIN then waits one cycle
    // for that slot's data to come back from the table.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = SCAN;
            end
            SCAN: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (counter == LAST_IDX) next_state = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign rd_addr = counter;

    // Shared comparator. The right edge of the block is formed at 33 bits,
    // so a block near the top of the coordinate range does not wrap around.
    // Later hits overwrite earlier ones, so the highest index wins.
    always_comb begin
        x_right     = {1'b0, rd_x} + 33'(BLOCK_WIDTH);
        slot_hit    = cmp_valid && rd_active && (rd_y == lat_y) &&
                      (lat_x >= rd_x) && ({1'b0, lat_x} <= x_right);
        work_hit_nx = work_hit;
        work_x_nx   = work_x;
        work_y_nx   = work_y;
        work_idx_nx = work_idx;
        if (slot_hit) begin
            work_hit_nx = 1'b1;
            work_x_nx   = rd_x;
            work_y_nx   = rd_y;
            work_idx_nx = cmp_idx;
        end
    end

    // Datapath: address counter, doodle latch, compare pipeline, working
    // registers and result registers. Results are loaded on the edge that
    // leaves DRAIN. That way they first show up in the same cycle as done,
    // and they include the last slot's comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter        <= '0;
            lat_x          <= '0;
            lat_y          <= '0;
            cmp_valid      <= 1'b0;
            cmp_idx        <= '0;
            work_hit       <= 1'b0;
            work_x         <= '0;
            work_y         <= '0;
            work_idx       <= '0;
            hasCollide     <= 1'b0;
            collisionX     <= '0;
            collisionY     <= '0;
            collisionIndex <= '0;
        end else begin
            cmp_valid <= rd_en;
            cmp_idx   <= rd_addr;

            if (state == IDLE) begin
                if (start) begin
                    lat_x    <= doodleX;
                    lat_y    <= doodleY;
                    counter  <= '0;
                    work_hit <= 1'b0;
                    work_x   <= '0;
                    work_y   <= '0;
                    work_idx <= '0;
                end
            end else begin
                work_hit <= work_hit_nx;
                work_x   <= work_x_nx;
                work_y   <= work_y_nx;
                work_idx <= work_idx_nx;
            end

            if (state == SCAN) begin
                counter <= (counter == LAST_IDX) ? '0 : counter + IDX_W'(1);
            end

            if (state == DRAIN) begin
                hasCollide     <= work_hit_nx;
                collisionX     <= work_x_nx;
                collisionY     <= work_y_nx;
                collisionIndex <= work_idx_nx;
            end
        end
    end

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// tb_collision_scan_ctrl
//
// Purpose:
//   Self-checking bench for collision_scan_ctrl. The design is configured
//   with four block slots. A small table model answers reads with one cycle
//   of latency. Expected results come from a slot-by-slot rule evaluation
//   over the table contents.
//
// Ports: none (top-level bench).

module tb_collision_scan_ctrl;

    localparam int SW = 80;
    localparam int SH = 10;
    localparam int BW = 40;
    localparam int BH = 5;
    localparam int NB = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [31:0]   doodleX, doodleY;
    logic          rd_en;
    logic [IW-1:0] rd_addr;
    logic [31:0]   rd_x, rd_y;
    logic          rd_active;
    logic          busy, done, hasCollide;
    logic [31:0]   collisionX, collisionY;
    logic [IW-1:0] collisionIndex;

    logic [31:0] tx [NB];
    logic [31:0] ty [NB];
    logic        ta [NB];

    // Expected values of the previously completed scan, which the result
    // outputs must keep holding while the next scan runs.
    logic          ph;
    logic [31:0]   px, py;
    logic [IW-1:0] pi;

    int total = 0;
    int bad   = 0;

    collision_scan_ctrl #(
        .SCREEN_WIDTH (SW),
        .SCREEN_HEIGHT(SH),
        .BLOCK_WIDTH  (BW),
        .BLOCK_HEIGHT (BH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .doodleX       (doodleX),
        .doodleY       (doodleY),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_active     (rd_active),
        .busy          (busy),
        .done          (done),
        .hasCollide    (hasCollide),
        .collisionX    (collisionX),
        .collisionY    (collisionY),
        .collisionIndex(collisionIndex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block table model: registered read, one cycle of latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_x      <= tx[rd_addr];
            rd_y      <= ty[rd_addr];
            rd_active <= ta[rd_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference rule: look at every active slot on the doodle's row whose
    // inclusive window [x, x+BW] contains the doodle X. The last such slot
    // wins. The window is evaluated with 64-bit arithmetic.
    function automatic void model(input logic [31:0] dx, input logic [31:0] dy,
                                  output logic h, output logic [31:0] cx,
                                  output logic [31:0] cy, output logic [IW-1:0] ci);
        h  = 1'b0;
        cx = '0;
        cy = '0;
        ci = '0;
        for (int k = 0; k < NB; k++) begin
            if (ta[k] && (ty[k] == dy) && (longint'(dx) >= longint'(tx[k])) &&
                (longint'(dx) <= longint'(tx[k]) + longint'(BW))) begin
                h  = 1'b1;
                cx = tx[k];
                cy = ty[k];
                ci = IW'(k);
            end
        end
    endfunction

    task automatic clearTable();
        for (int k = 0; k < NB; k++) begin
            tx[k] = '0;
            ty[k] = '0;
            ta[k] = 1'b0;
        end
    endtask

    // One complete scan. start is sampled at edge T0. The checks then walk
    // through cycles T0+1 .. T0+6 and one idle cycle after done. With
    // disturb set, doodleX is changed at T0+1 and start is pulsed again at
    // T0+2. Neither may affect this scan.
    task automatic applyStimulus(input logic [31:0] dx, input logic [31:0] dy,
                                 input bit disturb);
        logic          h;
        logic [31:0]   cx, cy;
        logic [IW-1:0] ci;
        model(dx, dy, h, cx, cy, ci);
        @(negedge clk);
        doodleX = dx;
        doodleY = dy;
        start   = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                if (disturb) doodleX = dx + 32'd500;
            end
            if (c == 2 && disturb) start = 1'b1;
            if (c == 3) start = 1'b0;
            if (c <= 4) begin
                checkOutput("rd_en_scan", 64'(rd_en), 64'd1);
                checkOutput("rd_addr", 64'(rd_addr), 64'(c - 1));
            end else begin
                checkOutput("rd_en_off", 64'(rd_en), 64'd0);
            end
            if (c <= 5) begin
                checkOutput("busy", 64'(busy), 64'd1);
                checkOutput("done_early", 64'(done), 64'd0);
                checkOutput("hold_hit", 64'(hasCollide), 64'(ph));
                checkOutput("hold_x", 64'(collisionX), 64'(px));
                checkOutput("hold_y", 64'(collisionY), 64'(py));
                checkOutput("hold_idx", 64'(collisionIndex), 64'(pi));
            end else begin
                checkOutput("done", 64'(done), 64'd1);
                checkOutput("busy_at_done", 64'(busy), 64'd0);
                checkOutput("hasCollide", 64'(hasCollide), 64'(h));
                checkOutput("collisionX", 64'(collisionX), 64'(cx));
                checkOutput("collisionY", 64'(collisionY), 64'(cy));
                checkOutput("collisionIndex", 64'(collisionIndex), 64'(ci));
            end
        end
        ph = h;
        px = cx;
        py = cy;
        pi = ci;
        @(negedge clk);
        checkOutput("done_pulse_end", 64'(done), 64'd0);
        checkOutput("idle_hold_hit", 64'(hasCollide), 64'(ph));
        checkOutput("idle_hold_idx", 64'(collisionIndex), 64'(pi));
    endtask

    initial begin
        $display("[TB] collision_scan_ctrl bench start");
        rst_n   = 1'b0;
        start   = 1'b0;
        doodleX = '0;
        doodleY = '0;
        ph = 1'b0; px = '0; py = '0; pi = '0;
        clearTable();

        // Reset state.
        #1;
        checkOutput("rst_rd_en", 64'(rd_en), 64'd0);
        checkOutput("rst_rd_addr", 64'(rd_addr), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_hit", 64'(hasCollide), 64'd0);
        checkOutput("rst_x", 64'(collisionX), 64'd0);
        checkOutput("rst_y", 64'(collisionY), 64'd0);
        checkOutput("rst_idx", 64'(collisionIndex), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single hit in slot 2.
        $display("[TB] single hit");
        tx[2] = 32'd100; ty[2] = 32'd50; ta[2] = 1'b1;
        applyStimulus(32'd120, 32'd50, 1'b0);

        // Edge of the window and priority between two hits.
        $display("[TB] edge and priority");
        clearTable();
        tx[0] = 32'd100; ty[0] = 32'd50; ta[0] = 1'b1;
        tx[3] = 32'd140; ty[3] = 32'd50; ta[3] = 1'b1;
        applyStimulus(32'd140, 32'd50, 1'b0);
        applyStimulus(32'd141, 32'd50, 1'b0);
        applyStimulus(32'd181, 32'd50, 1'b0);

        // Row mismatch and inactive slot give no hit.
        $display("[TB] no hit");
        clearTable();
        tx[1] = 32'd100; ty[1] = 32'd51; ta[1] = 1'b1;
        tx[2] = 32'd100; ty[2] = 32'd50; ta[2] = 1'b0;
        applyStimulus(32'd100, 32'd50, 1'b0);

        // Ignored start during scan and doodle latching.
        $display("[TB] ignored start and latch");
        clearTable();
        tx[1] = 32'd100; ty[1] = 32'd50; ta[1] = 1'b1;
        applyStimulus(32'd110, 32'd50, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("no_second_done", 64'(done), 64'd0);
            checkOutput("no_second_busy", 64'(busy), 64'd0);
        end

        // Reset in the middle of a scan.
        $display("[TB] reset mid-scan");
        @(negedge clk);
        doodleX = 32'd50;
        doodleY = 32'd50;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_rd_en", 64'(rd_en), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_hit", 64'(hasCollide), 64'd0);
        checkOutput("midrst_x", 64'(collisionX), 64'd0);
        checkOutput("midrst_idx", 64'(collisionIndex), 64'd0);
        ph = 1'b0; px = '0; py = '0; pi = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("postrst_done", 64'(done), 64'd0);
        end
        applyStimulus(32'd120, 32'd50, 1'b0);

        // Window right edge beyond 32 bits.
        $display("[TB] overflow");
        clearTable();
        tx[0] = 32'hFFFF_FFF0; ty[0] = 32'd7; ta[0] = 1'b1;
        applyStimulus(32'hFFFF_FFFF, 32'd7, 1'b0);

        // Random tables and doodles.
        $display("[TB] random scans");
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < NB; k++) begin
                tx[k] = 32'($urandom_range(0, 200));
                ty[k] = 32'($urandom_range(0, 2));
                ta[k] = 1'($urandom_range(0, 1));
            end
            applyStimulus(32'($urandom_range(0, 260)), 32'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collision_scan_ctrl.md
# collision_scan_ctrl

Sequential scheduler that replaces the all-blocks-in-parallel collision comparison with a one-block-per-cycle scan over the platform table. On a start request it latches the doodle position and walks every block slot through a single read port on the block table (one-cycle read latency). It compares each entry with one shared comparator and reports the winning hit with a done pulse. It sits between the game-tick sequencer (which issues start) and the block table RAM.

## Interface

Parameters:
- SCREEN_WIDTH, default 400: playfield width in pixels.
- SCREEN_HEIGHT, default 700: playfield height in pixels.
- BLOCK_WIDTH, default 40: block width in pixels; the hit window is inclusive.
- BLOCK_HEIGHT, default 5: block height in pixels.
- Derived localparams:
  - COUNT_BLOCKS = (SCREEN_WIDTH/BLOCK_WIDTH)*(SCREEN_HEIGHT/BLOCK_HEIGHT). The default is 1400.
  - IDX_W = $clog2(COUNT_BLOCKS), minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  scan request; sampled only in IDLE.
- doodleX  in  32  doodle X position; latched on start acceptance.
- doodleY  in  32  doodle Y position; latched on start acceptance.
- rd_en  out  1  table read strobe.
- rd_addr  out  IDX_W  table slot index.
- rd_x  in  32  block X of the slot addressed in the previous cycle.
- rd_y  in  32  block Y of the slot addressed in the previous cycle.
- rd_active  in  1  active flag of the slot addressed in the previous cycle.
- busy  out  1  high from start acceptance through the cycle before done.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- hasCollide  out  1  a hit was found in the last completed scan.
- collisionX  out  32  block X of the winning slot.
- collisionY  out  32  block Y of the winning slot.
- collisionIndex  out  IDX_W  index of the winning slot.

## Operation

- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE -> SCAN when start=1. In that cycle latch doodleX/doodleY, clear the working hit registers and set the address counter to 0.
  - SCAN: rd_en=1, rd_addr=counter, and the counter increments each cycle. When counter==COUNT_BLOCKS-1, go to DRAIN.
  - DRAIN: rd_en=0. This is one cycle that evaluates the data for the last slot.
  - DONE: copy the working registers into the result outputs, pulse done, then go to IDLE.
- Compare stage, registered valid bit delayed one cycle from rd_en. A slot hits when all of the following hold:
  - rd_active=1;
  - rd_y == latched Y;
  - latched X >= rd_x;
  - latched X <= rd_x + BLOCK_WIDTH.
- The sum is computed at 33 bits, so there is no wrap-around. rd_x=32'hFFFF_FFF0 with X=32'hFFFF_FFFF is a hit.
- Priority: when several slots hit, the highest index wins, because later hits overwrite earlier ones.
- The result outputs (hasCollide, collisionX/Y, collisionIndex) change only in DONE. They hold their values through IDLE and through the following scan until that scan's DONE.
- When no slot hits: hasCollide=0, and collisionX, collisionY and collisionIndex are 0.
- start while busy, in DRAIN or in DONE is ignored. No queueing.
- doodleX/doodleY changes after acceptance do not affect the scan in progress.

## Timing

- Reset values, asynchronous on rst_n low: state IDLE, rd_en=0, rd_addr=0, busy=0, done=0, hasCollide=0, collisionX=0, collisionY=0, collisionIndex=0, counter 0, working registers 0.
- Reset mid-scan aborts immediately. Outputs return to their reset values and no done is issued.
- Let start be sampled high at edge T0.
  - rd_addr=k is driven with rd_en=1 in cycle T0+1+k, for k=0..COUNT_BLOCKS-1.
  - The data for slot k is expected at cycle T0+2+k.
  - done is high in cycle T0+COUNT_BLOCKS+2, and results are valid in the same cycle.
  - busy is high for cycles T0+1 .. T0+COUNT_BLOCKS+1.
- Total scan latency is COUNT_BLOCKS+2 cycles. The earliest next start is sampled in the cycle after done.
- Back-to-back operation: start held high continuously gives one scan every COUNT_BLOCKS+3 cycles.

## Test plan

All tests use SCREEN_WIDTH=80, SCREEN_HEIGHT=10, BLOCK_WIDTH=40, BLOCK_HEIGHT=5, so COUNT_BLOCKS=4 and done arrives 6 cycles after start.

- Single hit: slot 2 = (x=100, y=50, active), other slots inactive; doodle=(120,50); start -> done at T0+6, hasCollide=1, collisionX=100, collisionY=50, collisionIndex=2.
- Edge and priority:
  - slot 0 = (100,50) and slot 3 = (140,50), both active; doodle=(140,50) -> hit, collisionIndex=3, collisionX=140.
  - Repeat with doodle=(141,50) -> collisionIndex=3.
  - Repeat with doodle=(181,50) -> hasCollide=0.
- No hit, and Y/active mismatch: slot 1 = (100,51, active) and slot 2 = (100,50, inactive); doodle=(100,50) -> hasCollide=0 and all outputs 0 at done.
- Ignored start and latch:
  - Pulse start again at T0+2 and change doodleX at T0+1 -> exactly one done at T0+6 with a result based on the original doodle.
  - rd_addr sequence is 0, 1, 2, 3 in cycles T0+1..T0+4.
- Reset mid-scan:
  - Assert rst_n=0 at T0+3 -> busy, rd_en and done go to 0 immediately, and prior results clear to 0.
  - After release, a new start completes normally in 6 cycles.
- Overflow: slot 0 = (32'hFFFF_FFF0, 7, active); doodle=(32'hFFFF_FFFF, 7) -> hasCollide=1, collisionIndex=0.
